// File: rtl/uart_mmio.sv
// Memory-mapped UART: TXD/RXD/CON registers, 8N1 transmitter and receiver
// with interrupt request; bit timing set by BAUD_DIV clock cycles per bit.
module uart_mmio #(
  parameter logic [15:0] BAUD_DIV = 16'd5208,
  parameter logic [31:0] BASE     = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam logic [31:0] TXD_ADDR  = BASE;
  localparam logic [31:0] RXD_ADDR  = BASE + 32'd4;
  localparam logic [31:0] CON_ADDR  = BASE + 32'd8;
  localparam logic [15:0] BIT_LAST  = BAUD_DIV - 16'd1;
  localparam logic [15:0] HALF_LAST = (BAUD_DIV >> 1) - 16'd1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t   tx_state, tx_state_n;
  rx_state_t   rx_state, rx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n, rx_bit, rx_bit_n, tx_bit_inc;
  logic        tx_out_n, tx_load, tx_done_set, rx_load;
  logic [7:0]  tx_byte, rx_data, rx_shift, rx_shift_n;
  logic        tx_ie, rx_ie, tx_done, rx_valid, overrun, tx_busy;
  logic        rx_meta, rx_sync;
  logic        sel_txd, sel_rxd, sel_con;
  logic        wr_txd, wr_con, rd_rxd_clr, rd_con_clr;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[31:8];

  assign sel_txd    = (addr == TXD_ADDR);
  assign sel_rxd    = (addr == RXD_ADDR);
  assign sel_con    = (addr == CON_ADDR);
  assign wr_txd     = wr & sel_txd;
  assign wr_con     = wr & sel_con;
  assign rd_rxd_clr = rd & sel_rxd;
  // a simultaneous CON write wins, so its read side effect is suppressed
  assign rd_con_clr = rd & ~wr & sel_con;

  assign tx_busy = (tx_state != TX_IDLE);
  assign irqout  = (tx_ie & tx_done) | (rx_ie & rx_valid);

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_txd)      rdata = {24'b0, tx_byte};
      else if (sel_rxd) rdata = {24'b0, rx_data};
      else if (sel_con) rdata = {26'b0, overrun, tx_busy, rx_valid, tx_done, rx_ie, tx_ie};
    end
  end

  // Transmitter next-state
  always_comb begin
    tx_state_n  = tx_state;
    tx_cnt_n    = tx_cnt;
    tx_bit_n    = tx_bit;
    tx_out_n    = uart_tx;
    tx_load     = 1'b0;
    tx_done_set = 1'b0;
    tx_bit_inc  = tx_bit + 3'd1;
    case (tx_state)
      TX_IDLE: begin
        tx_out_n = 1'b1;
        if (wr_txd) begin
          tx_load    = 1'b1;
          tx_state_n = TX_START;
          tx_cnt_n   = '0;
          tx_out_n   = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_out_n   = tx_byte[0];
        end else begin
          tx_cnt_n = tx_cnt + 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            tx_state_n = TX_STOP;
            tx_out_n   = 1'b1;
          end else begin
            tx_bit_n = tx_bit_inc;
            tx_out_n = tx_byte[tx_bit_inc];
          end
        end else begin
          tx_cnt_n = tx_cnt + 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_n  = TX_IDLE;
          tx_cnt_n    = '0;
          tx_done_set = 1'b1;
        end else begin
          tx_cnt_n = tx_cnt + 16'd1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // Receiver next-state; the start bit is re-checked half a bit in
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_load    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_state_n = RX_START;
          rx_cnt_n   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
          rx_load    = rx_sync;
        end else begin
          rx_cnt_n = rx_cnt + 16'd1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      uart_tx  <= 1'b1;
      tx_byte  <= '0;
      tx_done  <= 1'b0;
      tx_ie    <= 1'b0;
      rx_ie    <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      uart_tx  <= tx_out_n;
      if (tx_load) tx_byte <= wdata[7:0];
      if (tx_done_set)     tx_done <= 1'b1;
      else if (rd_con_clr) tx_done <= 1'b0;
      if (wr_con) begin
        rx_ie <= wdata[1];
        tx_ie <= wdata[0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      rx_meta  <= uart_rx;
      rx_sync  <= rx_meta;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      if (rx_load) rx_data <= rx_shift;
      if (rx_load)         rx_valid <= 1'b1;
      else if (rd_rxd_clr) rx_valid <= 1'b0;
      if (rx_load && rx_valid) overrun <= 1'b1;
      else if (rd_con_clr)     overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio at BAUD_DIV = 4: register map, TX/RX framing,
// overrun, interrupts, glitch/framing rejection and mid-frame reset.
module tb_uart_mmio;

  localparam logic [31:0] TXD = 32'h4000_0018;
  localparam logic [31:0] RXD = 32'h4000_001C;
  localparam logic [31:0] CON = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset, rd, wr, uart_rx;
  logic [31:0] addr, wdata, rdata;
  logic        irqout, uart_tx;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  uart_mmio #(.BAUD_DIV(16'd4), .BASE(32'h4000_0018)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .irqout(irqout), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // combinational read with no clock edge, so no read side effects
  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1;
    #1 d = rdata;
    rd = 1'b0; addr = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; rd = 1'b1;
    #1 d = rdata;
    @(posedge clk); #1;
    rd = 1'b0; addr = '0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk); uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (4) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  // Start a frame and check every serial cycle plus busy; optionally
  // attempt a second TXD write mid-frame which must be ignored.
  task automatic tx_frame(input logic [7:0] b, input bit inject);
    logic [31:0] d;
    logic        exp;
    bus_write(TXD, {24'b0, b});
    for (int i = 0; i < 40; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        wr = 1'b0; addr = '0;
      end
      if (i < 4)       exp = 1'b0;
      else if (i < 36) exp = b[(i - 4) / 4];
      else             exp = 1'b1;
      check($sformatf("tx_line[%0d]", i), uart_tx, exp);
      peek(CON, d);
      check($sformatf("tx_busy[%0d]", i), d[4], 1'b1);
      if (inject && i == 10) begin
        addr = TXD; wdata = 32'hFF; wr = 1'b1;
      end
    end
    @(posedge clk); #1;
    check("tx_idle_line", uart_tx, 1'b1);
    peek(CON, d);
    check("tx_busy_end", d[4], 1'b0);
    check("tx_done_end", d[2], 1'b1);
    peek(TXD, d);
    check("tx_byte_kept", d, {24'b0, b});
  endtask

  initial begin
    logic [31:0] d;
    bit found;
    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; uart_rx = 1'b1;

    repeat (3) @(posedge clk); #1;
    check("rst_tx", uart_tx, 1'b1);
    check("rst_irq", irqout, 1'b0);
    peek(CON, d); check("rst_con", d, 32'h0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_tx", uart_tx, 1'b1);

    // address decode and read gating
    peek(CON + 32'd4, d); check("unmapped_rd", d, 32'h0);
    peek(TXD - 32'd4, d); check("unmapped_rd2", d, 32'h0);
    bus_write(CON + 32'd4, 32'hA5);
    peek(CON, d); check("unmapped_wr", d, 32'h0);
    check("unmapped_wr_tx", uart_tx, 1'b1);
    bus_write(CON, 32'hFFFF_FFFE);
    addr = CON; #1 check("rd_low_gate", rdata, 32'h0); addr = '0;
    peek(CON, d); check("con_ie_only", d, 32'h2);
    bus_write(CON, 32'h0);

    // transmit 0xA5 with an ignored write while busy
    tx_frame(8'hA5, 1'b1);
    bus_read(CON, d); check("con_rd_done", d, 32'h04);
    peek(CON, d); check("done_cleared", d, 32'h0);

    // receive 0x3C
    send_frame(8'h3C, 1'b1);
    repeat (4) @(posedge clk); #1;
    peek(CON, d); check("rx_valid", d, 32'h08);
    check("rx_irq_masked", irqout, 1'b0);
    bus_read(RXD, d); check("rx_data", d, 32'h3C);
    peek(CON, d); check("rx_valid_clr", d, 32'h0);

    // overrun
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (4) @(posedge clk); #1;
    peek(RXD, d); check("ovr_data", d, 32'h22);
    bus_read(CON, d); check("ovr_con", d, 32'h28);
    peek(CON, d); check("ovr_clr", d, 32'h08);
    bus_read(RXD, d); check("ovr_rxd", d, 32'h22);
    peek(CON, d); check("ovr_all_clr", d, 32'h0);

    // interrupts
    bus_write(CON, 32'h3);
    peek(CON, d); check("irq_con", d, 32'h03);
    check("irq_idle", irqout, 1'b0);
    bus_write(TXD, 32'h55);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      peek(CON, d);
      found = d[2];
    end
    check("tx_done_wait", found, 1'b1);
    check("irq_tx", irqout, 1'b1);
    bus_read(CON, d); check("irq_con_rd", d, 32'h07);
    check("irq_tx_clr", irqout, 1'b0);
    send_frame(8'h96, 1'b1);
    repeat (4) @(posedge clk); #1;
    check("irq_rx", irqout, 1'b1);
    bus_read(RXD, d); check("irq_rx_data", d, 32'h96);
    check("irq_rx_clr", irqout, 1'b0);

    // glitch and framing error rejection
    @(negedge clk) uart_rx = 1'b0;
    @(negedge clk) uart_rx = 1'b1;
    repeat (12) @(posedge clk); #1;
    peek(CON, d); check("glitch", d, 32'h03);
    send_frame(8'h5A, 1'b0);
    repeat (8) @(posedge clk); #1;
    peek(CON, d); check("frame_err", d, 32'h03);
    peek(RXD, d); check("frame_err_data", d, 32'h96);

    // reset in the middle of data bit 3 of 0xC3
    bus_write(TXD, 32'hC3);
    repeat (17) @(posedge clk); #1;
    check("pre_rst_bit3", uart_tx, 1'b0);
    reset = 1'b0;
    #1;
    check("mid_rst_tx", uart_tx, 1'b1);
    check("mid_rst_irq", irqout, 1'b0);
    peek(CON, d); check("mid_rst_con", d, 32'h0);
    peek(RXD, d); check("mid_rst_rxd", d, 32'h0);
    peek(TXD, d); check("mid_rst_txd", d, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("post_rst_idle", uart_tx, 1'b1);
    tx_frame(8'h3A, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_mmio.md
UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 16'd5208, clock cycles per UART bit (50 MHz / 9600); legal range 4..65535.
REQ-002 SHALL have parameter BASE, default 32'h4000_0018, byte address of TXD; RXD at BASE+4, CON at BASE+8.
REQ-003 SHALL have port clk  input  1  CPU clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports rd and wr, each input  1  bus read and write strobes from the CPU datapath.
REQ-006 SHALL have ports addr  input  32 (bus byte address) and wdata  input  32 (store data).
REQ-007 SHALL have port rdata  output  32  read data; combinational.
REQ-008 SHALL have port irqout  output  1  interrupt request to CPU control.
REQ-009 SHALL have ports uart_rx  input  1  serial in (asynchronous) and uart_tx  output  1  serial out.

Function
REQ-010 SHALL decode addresses by full 32-bit equality; no other address has any effect, and rdata = 0 there.
REQ-011 SHALL drive rdata = 0 when rd = 0; otherwise TXD -> {24'b0, tx_byte}, RXD -> {24'b0, rx_data}, CON -> {26'b0, overrun, tx_busy, rx_valid, tx_done, rx_ie, tx_ie}.
REQ-012 SHALL let a CON write update only rx_ie = wdata[1] and tx_ie = wdata[0]; status bits are read-only.
REQ-013 SHALL drive irqout = (tx_ie & tx_done) | (rx_ie & rx_valid), combinationally from registers.
REQ-014 SHALL start transmit on a TXD write while the TX FSM is IDLE: capture wdata[7:0] into tx_byte and enter START on that edge; a TXD write while busy is ignored.
REQ-015 SHALL implement the TX FSM IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE, each non-IDLE bit held exactly BAUD_DIV cycles; a frame is 10*BAUD_DIV cycles.
REQ-016 SHALL drive uart_tx high in IDLE and STOP, low in START, and tx_byte[i] in DATA bit i, all from a register.
REQ-017 SHALL assert tx_busy whenever the TX FSM is not IDLE; on the final cycle of STOP it sets tx_done and returns to IDLE.
REQ-018 SHALL pass uart_rx through a two-flop synchronizer; RX logic sees only the synchronized value.
REQ-019 SHALL implement the RX FSM IDLE -> START -> DATA -> STOP -> IDLE; IDLE enters START when synchronized rx = 0.
REQ-020 SHALL, in START, wait BAUD_DIV/2 cycles and then resample: low -> DATA; high -> IDLE (glitch rejected).
REQ-021 SHALL, in DATA, sample once every BAUD_DIV cycles, 8 samples, shifting LSB first.
REQ-022 SHALL, in STOP, sample after BAUD_DIV cycles: high -> load rx_data and set rx_valid; if rx_valid was already 1, also set overrun, with the new data replacing the old; low (framing error) -> discard the byte with rx_data and flags unchanged; either way -> IDLE.
REQ-023 SHALL clear rx_valid on an RXD read edge (rd & addr==RXD) and clear tx_done and overrun on a CON read edge.
REQ-024 SHALL give set priority over clear when both occur on the same edge (rx_valid, overrun, tx_done).
REQ-025 SHALL allow TX and RX to run fully concurrently and independently.
REQ-026 SHALL give a write priority over a read on the same edge for the TXD and CON registers; rd and wr are not both asserted by the CPU, and no further behaviour is defined for that case.

Reset
REQ-027 SHALL, while reset = 0, asynchronously force both FSMs to IDLE, all counters to 0, uart_tx = 1, synchronizer flops = 1, and tx_byte, rx_data, tx_ie, rx_ie, tx_done, rx_valid and overrun to 0, giving irqout = 0.
REQ-028 SHALL abort any frame in progress on reset mid-operation; after release, uart_tx stays high until a new TXD write.

Verification (BAUD_DIV = 4)
REQ-029 SHALL pass: write TXD = 0x000000A5 -> uart_tx = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1; tx_busy is high for 40 cycles, then tx_done = 1.
REQ-030 SHALL pass: drive uart_rx with frame 0x3C -> rx_valid = 1 and RXD read = 0x0000003C; after the read edge, rx_valid = 0.
REQ-031 SHALL pass: two frames 0x11 then 0x22 with no read -> rx_data = 0x22, overrun = 1; a CON read clears overrun.
REQ-032 SHALL pass: CON = 0x3, then complete TX of 0x55 -> irqout = 1; a CON read -> irqout = 0 when rx_valid = 0.
REQ-033 SHALL pass: uart_rx low pulse of 1 cycle -> no rx_valid; a frame with stop bit 0 -> rx_valid stays 0.
REQ-034 SHALL pass: reset asserted mid-TX at bit 3 -> uart_tx = 1 immediately, tx_busy = 0, all status = 0; a TXD write after release -> frame starts normally.
